// File: rtl/adv7513_reg_dump_if.sv
// ----------------------------------------------------------------------------
// adv7513_reg_dump_if
// Bundles the two streaming sides of the register dump sequencer:
//   - reader command/response: rd_start, rd_reg_addr (to reader),
//                              rd_done, rd_reg_data (from reader)
//   - record stream:           out_valid, out_addr, out_data, out_err (to sink),
//                              out_ready (from sink)
// Modports:
//   master - the dump sequencer (drives commands and records)
//   slave  - the environment (register reader plus record sink)
// ----------------------------------------------------------------------------
interface adv7513_reg_dump_if;
    logic       rd_start;
    logic [7:0] rd_reg_addr;
    logic       rd_done;
    logic [7:0] rd_reg_data;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_addr;
    logic [7:0] out_data;
    logic       out_err;

    modport master (
        output rd_start, rd_reg_addr, out_valid, out_addr, out_data, out_err,
        input  rd_done, rd_reg_data, out_ready
    );

    modport slave (
        input  rd_start, rd_reg_addr, out_valid, out_addr, out_data, out_err,
        output rd_done, rd_reg_data, out_ready
    );
endinterface

// File: rtl/adv7513_reg_dump.sv
// ----------------------------------------------------------------------------
// adv7513_reg_dump
// Walks the register range START_ADDR..END_ADDR, issuing one read per address
// to the ADV7513 single-register reader and streaming each (address, data)
// pair out as a valid/ready record. A per-read timeout ends the dump with an
// error record if the reader never completes.
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-low reset
//   dump_go   - one-cycle dump request, ignored while busy
//   busy      - high whenever a dump is in progress
//   dump_done - one-cycle pulse at the end of a dump
//   dump_err  - dump ended by timeout; held until the next accepted dump_go
//   bus       - reader command/response and record stream (master side)
// ----------------------------------------------------------------------------
module adv7513_reg_dump #(
    parameter logic [7:0]  START_ADDR     = 8'h00,
    parameter logic [7:0]  END_ADDR       = 8'hFF,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dump_go,
    output logic                       busy,
    output logic                       dump_done,
    output logic                       dump_err,
    adv7513_reg_dump_if.master         bus
);

    localparam logic [23:0] TimeoutLast = TIMEOUT_CYCLES - 24'd1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StAck,
        StWait,
        StOut,
        StFin
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [23:0] cnt_q, cnt_d;
    logic        term_q, term_d;
    logic        err_q, err_d;
    logic        rd_start_q, rd_start_d;
    logic [7:0]  rd_addr_q, rd_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_addr_q, out_addr_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_err_q, out_err_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            addr_q      <= 8'h00;
            cnt_q       <= 24'd0;
            term_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_start_q  <= 1'b0;
            rd_addr_q   <= 8'h00;
            out_valid_q <= 1'b0;
            out_addr_q  <= 8'h00;
            out_data_q  <= 8'h00;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            term_q      <= term_d;
            err_q       <= err_d;
            rd_start_q  <= rd_start_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        term_d      = term_q;
        err_d       = err_q;
        rd_start_d  = 1'b0;
        rd_addr_d   = rd_addr_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;

        unique case (state_q)
            StIdle: begin
                if (dump_go) begin
                    addr_d  = START_ADDR;
                    err_d   = 1'b0;
                    term_d  = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                rd_addr_d  = addr_q;
                rd_start_d = 1'b1;
                cnt_d      = 24'd0;
                state_d    = StAck;
            end
            StAck, StWait: begin
                // A completed read wins over a timeout landing on the same cycle.
                if (state_q == StWait && bus.rd_done) begin
                    out_addr_d  = addr_q;
                    out_data_d  = bus.rd_reg_data;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end else if (cnt_q == TimeoutLast) begin
                    out_addr_d  = addr_q;
                    out_data_d  = 8'h00;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    err_d       = 1'b1;
                    term_d      = 1'b1;
                    state_d     = StOut;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                    // Reader drops its stale done level to acknowledge the command.
                    if (state_q == StAck && !bus.rd_done) begin
                        state_d = StWait;
                    end
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    // Compare before increment so END_ADDR of 8'hFF never wraps.
                    if (term_q || addr_q == END_ADDR) begin
                        state_d = StFin;
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        state_d = StIssue;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy            = (state_q != StIdle);
    assign dump_done       = (state_q == StFin);
    assign dump_err        = err_q;
    assign bus.rd_start    = rd_start_q;
    assign bus.rd_reg_addr = rd_addr_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_addr    = out_addr_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_err     = out_err_q;

endmodule

// File: tb/tb_adv7513_reg_dump.sv
// ----------------------------------------------------------------------------
// tb_adv7513_reg_dump
// Randomised bench for adv7513_reg_dump. A behavioural register reader answers
// each read with addr ^ key after a random delay (optionally with a stale done
// level, optionally hanging forever on one address). Expected records for a
// dump are queued when dump_go is issued; an independent monitor pops and
// compares each presented record and drives out_ready.
// ----------------------------------------------------------------------------
module tb_adv7513_reg_dump;

    localparam logic [7:0]  FIRST_ADDR = 8'hFC;
    localparam logic [7:0]  LAST_ADDR  = 8'hFF;
    localparam logic [23:0] TMO        = 24'd100;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       err;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic dump_go = 1'b0;
    logic busy, dump_done, dump_err;

    adv7513_reg_dump_if bus ();

    adv7513_reg_dump #(
        .START_ADDR    (FIRST_ADDR),
        .END_ADDR      (LAST_ADDR),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .dump_go  (dump_go),
        .busy     (busy),
        .dump_done(dump_done),
        .dump_err (dump_err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_starts = 0;
    int         start_cyc = 0;
    int         done_cyc = 0;
    int         rec_idx = 0;
    int         ready_mode = 0;
    bit         hang_en = 1'b0;
    logic [7:0] hang_addr = 8'h00;
    logic [7:0] key = 8'h00;
    rec_t       exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural register reader.
    initial begin : reader
        int         k, stale, lat;
        logic [7:0] cur;
        bit         pend, hang_now;
        k = 0; stale = 0; lat = 1; cur = 8'h00; pend = 1'b0; hang_now = 1'b0;
        bus.rd_done = 1'b1;
        bus.rd_reg_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend = 1'b0;
                bus.rd_done = 1'b1;
            end else begin
                if (bus.rd_start) begin
                    n_starts++;
                    chk("no_start_during_record", bus.out_valid, 0);
                    cur       = bus.rd_reg_addr;
                    start_cyc = cyc;
                    k         = 0;
                    stale     = $urandom_range(2, 0);
                    lat       = $urandom_range(20, 1);
                    pend      = 1'b1;
                    hang_now  = hang_en && (cur == hang_addr);
                end else if (pend) begin
                    chk("rd_addr_stable", bus.rd_reg_addr, cur);
                end
                if (pend) begin
                    if (k < stale) begin
                        bus.rd_done = 1'b1;
                    end else if (k < stale + lat || hang_now) begin
                        bus.rd_done = 1'b0;
                    end else begin
                        bus.rd_done     = 1'b1;
                        bus.rd_reg_data = cur ^ key;
                        done_cyc        = cyc;
                        pend            = 1'b0;
                    end
                    k++;
                end
            end
        end
    end

    // Record monitor / scoreboard and out_ready driver.
    initial begin : monitor
        bit   seen, r;
        int   held;
        rec_t cap, got, e;
        seen = 1'b0; r = 1'b0; held = 0; cap = '0; got = '0; e = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                seen = 1'b0;
            end else if (bus.out_valid) begin
                got = '{addr: bus.out_addr, data: bus.out_data, err: bus.out_err};
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_record", {15'd0, got}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rec_addr", got.addr, e.addr);
                        chk("rec_data", got.data, e.data);
                        chk("rec_err", got.err, e.err);
                        if (e.err) chk("timeout_latency", cyc - start_cyc, TMO);
                        else       chk("read_latency", cyc - done_cyc, 1);
                    end
                    seen = 1'b1;
                    held = 0;
                    cap  = got;
                    rec_idx++;
                end else begin
                    chk("record_stable", got, cap);
                    held++;
                end
                case (ready_mode)
                    0:       r = 1'b1;
                    1:       r = ($urandom_range(1, 0) == 1);
                    default: r = !(rec_idx == 2 && held < 10);
                endcase
                bus.out_ready = r;
                if (r) seen = 1'b0;
            end else begin
                bus.out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(1, 0) == 1);
            end
        end
    end

    // Queue the records the dump is expected to produce; returns read count.
    task automatic build_expected(input bit hang, input logic [7:0] haddr, output int n);
        int         a;
        logic [7:0] av;
        n = 0;
        a = FIRST_ADDR;
        forever begin
            av = 8'(a);
            n++;
            if (hang && av == haddr) begin
                exp_q.push_back('{addr: av, data: 8'h00, err: 1'b1});
                break;
            end
            exp_q.push_back('{addr: av, data: av ^ key, err: 1'b0});
            if (a >= int'(LAST_ADDR)) break;
            a++;
        end
    endtask

    task automatic check_reset_values();
        chk("rst_busy", busy, 0);
        chk("rst_dump_done", dump_done, 0);
        chk("rst_dump_err", dump_err, 0);
        chk("rst_rd_start", bus.rd_start, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_rd_reg_addr", bus.rd_reg_addr, 0);
        chk("rst_out_addr", bus.out_addr, 0);
        chk("rst_out_data", bus.out_data, 0);
    endtask

    task automatic run_dump(input bit hang, input logic [7:0] haddr, input int mode,
                            input bit extra_go);
        int exp_starts;
        bit got;
        key        = 8'($urandom);
        hang_en    = hang;
        hang_addr  = haddr;
        ready_mode = mode;
        n_starts   = 0;
        rec_idx    = 0;
        build_expected(hang, haddr, exp_starts);
        @(negedge clk);
        dump_go = 1'b1;
        @(negedge clk);
        dump_go = 1'b0;
        chk("busy_after_go", busy, 1);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            dump_go = extra_go && (i == 6);
            if (dump_done) begin
                got = 1'b1;
                break;
            end
        end
        dump_go = 1'b0;
        chk("dump_done_seen", got, 1);
        chk("records_left", exp_q.size(), 0);
        chk("dump_err_at_done", dump_err, hang);
        chk("rd_start_count", n_starts, exp_starts);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) chk("dump_done_width", dump_done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_rd_start", bus.rd_start, 0);
            chk("dump_err_held", dump_err, hang);
        end
        exp_q.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin : main
        int  n;
        bit  got;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b1;

        run_dump(1'b0, 8'h00, 0, 1'b0);   // plain dump, always ready
        run_dump(1'b0, 8'h00, 2, 1'b0);   // 10-cycle backpressure on record 2
        run_dump(1'b1, 8'hFE, 0, 1'b0);   // timeout mid-range
        run_dump(1'b0, 8'h00, 1, 1'b1);   // random ready, dump_go while busy
        run_dump(1'b1, 8'hFC, 1, 1'b0);   // timeout on first read

        // Reset in the middle of a dump.
        key = 8'($urandom); hang_en = 1'b0; ready_mode = 0; n_starts = 0; rec_idx = 0;
        build_expected(1'b0, 8'h00, n);
        @(negedge clk);
        dump_go = 1'b1;
        @(negedge clk);
        dump_go = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.rd_start && bus.rd_reg_addr == 8'hFE) begin
                got = 1'b1;
                break;
            end
        end
        chk("reached_fe_read", got, 1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", dump_done, 0);
            chk("no_record_after_reset", bus.out_valid, 0);
        end
        run_dump(1'b0, 8'h00, 1, 1'b0);

        for (int t = 0; t < 4; t++) begin
            run_dump(1'($urandom_range(1, 0)), 8'(FIRST_ADDR + 8'($urandom_range(3, 0))),
                     $urandom_range(2, 0), 1'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
